// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode constants and pointer width helper.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointer width: address bits plus one wrap-toggle bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param; master drives requests, slave is the FIFO.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);

    localparam int CW = ptr_w(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;
    logic [CW-1:0]    count;

    modport master (
        output wr_en, wdata, rd_en, clr_err,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               overflow, underflow, count
    );

    modport slave (
        input  wr_en, wdata, rd_en, clr_err,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               overflow, underflow, count
    );

endinterface

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage array: synchronous write port, asynchronous read port.
module fifo_mem_2p #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; pointers alone define which entries are valid,
    // and leaving it out lets synthesis map this onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, threshold flags, sticky error flags
// and selectable standard / first-word-fall-through read mode.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FIFO_MODE_STD
) (
    input  logic             clk,
    input  logic             res_n,
    sync_fifo_param_if.slave bus
);

    localparam int CW = ptr_w(DEPTH);
    localparam int AW = CW - 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
    end
    if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_chk_thresh
        $error("sync_fifo_param: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [CW-1:0]    count;
    logic             empty, full;
    logic             wa, ra;
    logic [WIDTH-1:0] mem_rdata;

    // Flags come only from registered pointers, so no request input reaches an output.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign wa = bus.wr_en & (~full | bus.rd_en);
    assign ra = bus.rd_en & ~empty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (wa) wr_ptr_d = wr_ptr_q + CW'(1);
        if (ra) rd_ptr_d = rd_ptr_q + CW'(1);
        // A new error in the same cycle as clr_err keeps the flag set.
        overflow_d  = (overflow_q  & ~bus.clr_err) | (bus.wr_en & ~wa);
        underflow_d = (underflow_q & ~bus.clr_err) | (bus.rd_en & empty);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wa),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (bus.wdata),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented directly; forced to zero while empty so reset reads as 0.
        assign bus.rdata  = empty ? '0 : mem_rdata;
        assign bus.rvalid = ~empty;
    end else begin : g_std
        logic [WIDTH-1:0] rdata_q, rdata_d;
        logic             rvalid_q, rvalid_d;

        always_comb begin
            rdata_d  = rdata_q;
            rvalid_d = ra;
            if (ra) rdata_d = mem_rdata;
        end

        always_ff @(posedge clk or negedge res_n) begin
            if (!res_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata_q  <= rdata_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign bus.rdata  = rdata_q;
        assign bus.rvalid = rvalid_q;
    end

    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = int'(count) >= AF_THRESH;
    assign bus.almost_empty = int'(count) <= AE_THRESH;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO for buffering data between producer and consumer logic in the same clock domain. Width, depth, almost-full/almost-empty thresholds and read mode (standard or first-word-fall-through) are set by parameters. It adds a fill-level count, sticky overflow/underflow flags with a clear input, and defined behaviour for simultaneous read and write at full and at empty. It is the common buffering primitive for single-domain datapaths and sits next to the dual-clock FIFO.

## Interface
- `WIDTH`, default 8: data word width in bits, ≥1.
- `DEPTH`, default 16: number of entries; power of two, ≥2.
- `AF_THRESH`, default DEPTH-2: `almost_full` is asserted when count ≥ AF_THRESH.
- `AE_THRESH`, default 2: `almost_empty` is asserted when count ≤ AE_THRESH.
- `FWFT`, default 0: read mode. 0 = standard, 1 = first-word-fall-through.

Ports (CW = $clog2(DEPTH)+1):
- `clk` input 1: single clock, rising edge.
- `res_n` input 1: reset, asynchronous assert, active-low.
- `wr_en` input 1: write request.
- `wdata` input WIDTH: write data.
- `rd_en` input 1: read request.
- `clr_err` input 1: synchronous clear of the sticky error flags.
- `rdata` output WIDTH: read data.
- `rvalid` output 1: `rdata` holds a valid word.
- `full`, `empty` output 1: occupancy flags.
- `almost_full`, `almost_empty` output 1: threshold flags.
- `overflow`, `underflow` output 1: sticky error flags.
- `count` output CW: number of stored words, 0..DEPTH.

## Operation
- Storage is DEPTH × WIDTH. `wr_ptr` and `rd_ptr` are each CW bits wide. The low bits index the array and the MSB is the wrap toggle.
- `count` = wr_ptr − rd_ptr, modulo 2^CW.
- `empty` = (wr_ptr == rd_ptr).
- `full` = low bits equal and MSBs differ.
- Write accepted (wa) = wr_en & (!full | rd_en). A write at full is allowed only when a read happens in the same cycle. Data goes to mem[wr_ptr] and wr_ptr increments, wrapping naturally.
- Read accepted (ra) = rd_en & !empty. A read at empty is rejected even if a write happens in the same cycle.
- Rejected write: `overflow` sets and stays at 1. Storage and pointers are unchanged.
- Rejected read: `underflow` sets and stays at 1. `rdata` is unchanged.
- `clr_err` clears both sticky flags on the next edge. If a new error occurs in the same cycle as `clr_err`, the error wins and the flag stays set.
- FWFT=0: on ra, `rdata` is registered from mem[rd_ptr] and `rvalid` pulses for one cycle. Otherwise `rdata` holds its last value and `rvalid`=0.
- FWFT=1: `rdata` = mem[rd_ptr] and `rvalid` = !empty, continuously. `rd_en` acts as a pop/acknowledge.
- Reset: `count`=0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0, `rdata`=0, `rvalid`=0, both pointers 0. Memory contents are not reset.
- Reset asserted mid-operation discards all contents immediately (asynchronously). The first write after `res_n` deasserts lands at entry 0.

## Timing
- All state changes on the rising edge of `clk`. Flags and `count` are derived from registered pointers and are valid one cycle after the accepting edge.
- Write-to-read latency:
  - FWFT=0: a word written at edge N can be read at edge N+1 (`rd_en` high during cycle N+1). `rdata`/`rvalid` are valid after edge N+1.
  - FWFT=1: `rdata` is valid after edge N.
- Simultaneous wa & ra: `count` is unchanged and both pointers advance.
- Pointer wrap: entry DEPTH-1 → 0 toggles the MSB. The full/empty distinction relies only on this toggle bit.
- No combinational path from `wr_en`/`rd_en` to any output.

## Structure
- Package `fifo_pkg` holds the `ptr_w(depth)` function (=$clog2(depth)+1) and the `FIFO_MODE_STD`/`FIFO_MODE_FWFT` constants.
- Elaboration checks: DEPTH is a power of two, and AE_THRESH < AF_THRESH ≤ DEPTH.
- One sub-module, `fifo_mem_2p`: simple dual-port array with a synchronous write port and an asynchronous read port. Control and flags live in `sync_fifo_param`.

## Test plan
- Reset, then WIDTH=8, DEPTH=4, FWFT=0. Write A0,A1,A2,A3 → `full`=1, `count`=4, `almost_full`=1. A fifth write → `overflow`=1, contents unchanged. Four reads → `rdata` = A0..A3 in order, then `empty`=1.
- Empty FIFO, `rd_en` with `wr_en` (wdata=55) in the same cycle → `underflow`=1, `count`=1. The next read returns 55.
- Full FIFO (DEPTH=4), `wr_en`+`rd_en` in the same cycle → `overflow` stays 0, `count` stays 4, and the oldest word is read out.
- Write/read 10 words through DEPTH=4 (wrap twice) → data order preserved. `full`/`empty` correct at each wrap, with `count` never exceeding 4.
- FWFT=1: write 0x3C → `rdata`=0x3C and `rvalid`=1 one cycle later with no `rd_en`. Pulse `rd_en` → `rvalid`=0.
- Set `overflow`, pulse `clr_err` → flag clears next cycle. Assert `res_n`=0 mid-stream with `count`=3 → all outputs at reset values immediately, without waiting for a clock edge.
